// File: rtl/frame_dispatcher.sv
// Captures a block of instruction frames on a program load and hands them, one
// frame at a time, to ready shader cores selected round-robin.
module frame_dispatcher #(
    parameter int CORE_NUM    = 4,
    parameter int INSTR_SIZE  = 32,
    parameter int DATA_DEPTH  = 8,
    parameter int CORE_W      = $clog2(CORE_NUM),
    parameter int IDX_W       = $clog2(DATA_DEPTH),
    parameter int BUS_TO_CORE = CORE_W + IDX_W + INSTR_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             prog_loading,
    input  logic [DATA_DEPTH*INSTR_SIZE-1:0] data_frames_in,
    input  logic [CORE_NUM-1:0]              core_ready,
    input  logic                             core_reading,
    output logic                             frame_being_sent,
    output logic [BUS_TO_CORE-1:0]           mess_to_core,
    output logic                             busy,
    output logic                             done
);
    typedef enum logic [1:0] {IDLE, ARB, SEND, DONE} state_t;

    state_t                state_reg;
    logic [INSTR_SIZE-1:0] frame_buf_reg [DATA_DEPTH];
    logic [INSTR_SIZE-1:0] frame_in [DATA_DEPTH];
    logic [IDX_W-1:0]      idx_reg;
    logic [CORE_W-1:0]     rr_ptr_reg;
    logic [CORE_W-1:0]     grant_reg;
    logic [CORE_W-1:0]     grant_next;
    logic [CORE_W-1:0]     grant_off;
    logic [CORE_W-1:0]     rr_after;
    logic [2*CORE_NUM-1:0] ready_dbl;
    logic [CORE_NUM-1:0]   ready_rot;
    logic                  any_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_DEPTH; gi++) begin : g_unpack
            assign frame_in[gi] = data_frames_in[gi*INSTR_SIZE +: INSTR_SIZE];
        end
    endgenerate

    // Rotate so bit 0 is the core at rr_ptr; the lowest set bit then wins.
    assign ready_dbl = {core_ready, core_ready};
    assign ready_rot = CORE_NUM'(ready_dbl >> rr_ptr_reg);
    assign any_ready = |core_ready;

    always_comb begin
        grant_off = '0;
        for (int i = CORE_NUM - 1; i >= 0; i--) begin
            if (ready_rot[i]) grant_off = CORE_W'(i);
        end
    end

    assign grant_next = CORE_W'((int'(rr_ptr_reg) + int'(grant_off)) % CORE_NUM);
    assign rr_after   = CORE_W'((int'(grant_reg) + 1) % CORE_NUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            for (int i = 0; i < DATA_DEPTH; i++) frame_buf_reg[i] <= '0;
            idx_reg          <= '0;
            rr_ptr_reg       <= '0;
            grant_reg        <= '0;
            frame_being_sent <= 1'b0;
            mess_to_core     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (prog_loading) begin
                        for (int i = 0; i < DATA_DEPTH; i++) frame_buf_reg[i] <= frame_in[i];
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= ARB;
                    end
                end
                ARB: begin
                    if (any_ready) begin
                        grant_reg        <= grant_next;
                        mess_to_core     <= {grant_next, idx_reg, frame_buf_reg[idx_reg]};
                        frame_being_sent <= 1'b1;
                        state_reg        <= SEND;
                    end
                end
                SEND: begin
                    // The grant is committed: core_ready is not looked at until the ack.
                    if (core_reading) begin
                        frame_being_sent <= 1'b0;
                        mess_to_core     <= '0;
                        rr_ptr_reg       <= rr_after;
                        if (idx_reg == IDX_W'(DATA_DEPTH - 1)) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + IDX_W'(1);
                            state_reg <= ARB;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_dispatcher.sv
// Bench for frame_dispatcher: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_frame_dispatcher;
    localparam int CORE_NUM    = 4;
    localparam int INSTR_SIZE  = 32;
    localparam int DATA_DEPTH  = 8;
    localparam int BUS_TO_CORE = 37;

    logic                             clk = 1'b0;
    logic                             reset = 1'b0;
    logic                             prog_loading = 1'b0;
    logic                             core_reading = 1'b0;
    logic [DATA_DEPTH*INSTR_SIZE-1:0] data_frames_in = '0;
    logic [CORE_NUM-1:0]              core_ready = '0;
    logic                             frame_being_sent;
    logic                             busy;
    logic                             done;
    logic [BUS_TO_CORE-1:0]           mess_to_core;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_dispatcher dut (
        .clk              (clk),
        .reset            (reset),
        .prog_loading     (prog_loading),
        .data_frames_in   (data_frames_in),
        .core_ready       (core_ready),
        .core_reading     (core_reading),
        .frame_being_sent (frame_being_sent),
        .mess_to_core     (mess_to_core),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a list of frames; each frame goes to the first
    // ready core at or after the pointer, and is retired when that core acknowledges.
    logic                  m_active  = 1'b0;
    logic                  m_sending = 1'b0;
    logic                  m_done    = 1'b0;
    int                    m_cnt     = 0;
    int                    m_ptr     = 0;
    int                    m_core    = 0;
    int                    loads_done = 0;
    logic [INSTR_SIZE-1:0] m_frames [DATA_DEPTH];
    logic [BUS_TO_CORE-1:0] exp_mess;

    function automatic int first_ready(input int ptr, input logic [CORE_NUM-1:0] rdy);
        int r;
        r = -1;
        for (int k = 0; k < CORE_NUM; k++)
            if (r < 0 && rdy[(ptr + k) % CORE_NUM]) r = (ptr + k) % CORE_NUM;
        return r;
    endfunction

    function automatic logic [INSTR_SIZE-1:0] frame_of(input logic [DATA_DEPTH*INSTR_SIZE-1:0] d,
                                                       input int idx);
        return INSTR_SIZE'(d >> (idx * INSTR_SIZE));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active  <= 1'b0;
            m_sending <= 1'b0;
            m_done    <= 1'b0;
            m_cnt     <= 0;
            m_ptr     <= 0;
            m_core    <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (prog_loading) begin
                for (int i = 0; i < DATA_DEPTH; i++) m_frames[i] <= frame_of(data_frames_in, i);
                m_active <= 1'b1;
                m_cnt    <= 0;
            end
        end else if (!m_sending) begin
            if (first_ready(m_ptr, core_ready) >= 0) begin
                m_core    <= first_ready(m_ptr, core_ready);
                m_sending <= 1'b1;
            end
        end else if (core_reading) begin
            m_sending <= 1'b0;
            m_ptr     <= (m_core + 1) % CORE_NUM;
            if (m_cnt == DATA_DEPTH - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign exp_mess = m_sending ? {m_core[1:0], m_cnt[2:0], m_frames[m_cnt]} : '0;

    always @(negedge clk) begin
        check("model_fbs",  64'(frame_being_sent), 64'(m_sending));
        check("model_mess", 64'(mess_to_core),     64'(exp_mess));
        check("model_busy", 64'(busy),             64'(m_active));
        check("model_done", 64'(done),             64'(m_done));
        if (m_done) begin
            loads_done <= loads_done + 1;
            $display("load %0d complete at %0t", loads_done + 1, $time);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [DATA_DEPTH*INSTR_SIZE-1:0] d);
        data_frames_in = d;
        prog_loading   = 1'b1;
        tick();
        prog_loading   = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done=%b, expected 1 within %0d cycles", name, done, limit);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 2000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_DEPTH*INSTR_SIZE-1:0] frames_a;
        logic [DATA_DEPTH*INSTR_SIZE-1:0] frames_b;
        logic [BUS_TO_CORE-1:0]           held;
        logic [BUS_TO_CORE-1:0]           lit5;
        int n2, ndone, got_done;

        for (int i = 0; i < DATA_DEPTH; i++) begin
            frames_a[i*INSTR_SIZE +: INSTR_SIZE] = 32'hA000_0000 + 32'(i);
            frames_b[i*INSTR_SIZE +: INSTR_SIZE] = 32'hB000_0000 + 32'(i * 16 + 7);
        end
        lit5 = {2'd1, 3'd5, 32'hA000_0005};

        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_fbs",  64'(frame_being_sent), 64'(0));
        check("reset_mess", 64'(mess_to_core),     64'(0));
        check("reset_busy", 64'(busy),             64'(0));
        check("reset_done", 64'(done),             64'(0));

        // All cores ready, ack tied high: frame i in cycle 2+2i to core i mod 4.
        core_ready   = 4'b1111;
        core_reading = 1'b1;
        load(frames_a);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) tick();
            if (c == 1) check("t2_busy_c1", 64'(busy), 64'(1));
            if (c >= 2 && c <= 16 && (c % 2) == 0) begin
                check("t2_fbs_even", 64'(frame_being_sent), 64'(1));
                check("t2_mess", 64'(mess_to_core),
                      64'({2'((c - 2) / 2 % 4), 3'((c - 2) / 2), 32'hA000_0000 + 32'((c - 2) / 2)}));
                if (c == 12) check("t2_mess_i5_literal", 64'(mess_to_core), 64'(lit5));
            end else begin
                check("t2_fbs_odd", 64'(frame_being_sent), 64'(0));
            end
            check("t2_done_c17_only", 64'(done), 64'(c == 17));
        end

        // Asynchronous reset mid-cycle while a frame is held on the bus.
        core_reading = 1'b0;
        load(frames_a);
        tick();
        check("t1_pre_fbs", 64'(frame_being_sent), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("t1_async_fbs",  64'(frame_being_sent), 64'(0));
        check("t1_async_mess", 64'(mess_to_core),     64'(0));
        check("t1_async_busy", 64'(busy),             64'(0));
        check("t1_async_done", 64'(done),             64'(0));
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t1_after_busy", 64'(busy), 64'(0));
        check("t1_after_fbs",  64'(frame_being_sent), 64'(0));

        // Only core 2 ready.
        core_ready   = 4'b0100;
        core_reading = 1'b1;
        load(frames_a);
        n2 = 0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (frame_being_sent && mess_to_core[36:35] == 2'd2) n2++;
            if (done) ndone++;
            tick();
        end
        check("t3_core2_frames", 64'(n2), 64'(8));
        check("t3_done_pulses",  64'(ndone), 64'(1));

        // Stall with no ready core, then only core 1.
        core_ready = 4'b0000;
        load(frames_a);
        for (int c = 0; c < 5; c++) begin
            check("t4_stall_fbs", 64'(frame_being_sent), 64'(0));
            tick();
        end
        core_ready = 4'b0010;
        tick();
        check("t4_first_fbs",  64'(frame_being_sent), 64'(1));
        check("t4_first_core", 64'(mess_to_core[36:35]), 64'(1));
        check("t4_first_idx",  64'(mess_to_core[34:32]), 64'(0));
        wait_done(60, "t4_done");
        tick();

        // Ack withheld for 3 cycles while core_ready drops.
        core_ready   = 4'b1111;
        core_reading = 1'b0;
        load(frames_a);
        tick();
        check("t5_fbs_start", 64'(frame_being_sent), 64'(1));
        held = mess_to_core;
        core_ready = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_hold_mess", 64'(mess_to_core), 64'(held));
            check("t5_hold_fbs",  64'(frame_being_sent), 64'(1));
        end
        core_reading = 1'b1;
        tick();
        check("t5_released_fbs", 64'(frame_being_sent), 64'(0));
        core_ready = 4'b1111;
        wait_done(60, "t5_done");
        tick();

        // Second load request mid-load must be ignored.
        load(frames_a);
        repeat (4) tick();
        data_frames_in = frames_b;
        prog_loading   = 1'b1;
        tick();
        prog_loading   = 1'b0;
        got_done = 0;
        for (int c = 0; c < 40 && got_done == 0; c++) begin
            if (frame_being_sent)
                check("t6_first_capture", 64'(mess_to_core[31:0]),
                      64'(frame_of(frames_a, int'(mess_to_core[34:32]))));
            if (done) got_done = 1;
            else tick();
        end
        check("t6_done_seen", 64'(got_done), 64'(1));
        tick();
        load(frames_b);
        tick();
        check("t6_second_fbs",   64'(frame_being_sent), 64'(1));
        check("t6_second_frame", 64'(mess_to_core[31:0]), 64'(32'hB000_0007));
        wait_done(60, "t6_second_done");
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            core_ready   = 4'($urandom);
            core_reading = ($urandom_range(0, 3) != 0);
            prog_loading = ($urandom_range(0, 5) == 0);
            if (prog_loading)
                for (int i = 0; i < DATA_DEPTH; i++)
                    data_frames_in[i*INSTR_SIZE +: INSTR_SIZE] = $urandom;
            tick();
        end
        prog_loading = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_dispatcher.md
Name: frame_dispatcher

Overview:
Sequencer between the host program-load interface and the shader cores. On a program-load request it captures a block of DATA_DEPTH instruction frames, then hands them to ready cores one frame at a time. It selects the target core round-robin and holds each message on the core bus until the addressed core acknowledges it. It drives the frame_being_sent / mess_to_core side of the top-level GPU interface.

Parameters:
CORE_NUM, 4, number of cores; core_ready width
INSTR_SIZE, 32, bits per instruction frame
DATA_DEPTH, 8, frames captured per load
CORE_W, $clog2(CORE_NUM), core-id field width
IDX_W, $clog2(DATA_DEPTH), frame-index field width
BUS_TO_CORE, CORE_W+IDX_W+INSTR_SIZE, message width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
prog_loading  input  1  load request, sampled only in IDLE
data_frames_in  input  DATA_DEPTH*INSTR_SIZE  packed frames; frame i = bits [i*INSTR_SIZE +: INSTR_SIZE]
core_ready  input  CORE_NUM  bit k=1 means core k can accept a frame
core_reading  input  1  acknowledge from the addressed core, meaningful only while frame_being_sent=1
frame_being_sent  output  1  message valid
mess_to_core  output  BUS_TO_CORE  {core_id[CORE_W], frame_idx[IDX_W], frame[INSTR_SIZE]}, MSB first
busy  output  1  load in progress
done  output  1  one-cycle pulse after the last frame is acknowledged

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; frame buffer, idx, rr_ptr and grant cleared to 0. Outputs frame_being_sent, mess_to_core, busy and done are all 0 immediately. A reset during SEND aborts the load; no partial state survives.
- All outputs are registered. mess_to_core=0 whenever frame_being_sent=0.
- States: IDLE, ARB, SEND, DONE.
- IDLE: if prog_loading=1 at a clock edge, capture all frames, set idx=0 and go to ARB. busy=1 from the next cycle.
- ARB: search core_ready starting at rr_ptr and wrapping mod CORE_NUM; the first set bit becomes grant. On a grant, go to SEND, load mess_to_core={grant, idx, frame[idx]} and set frame_being_sent=1 in the same registered update. If core_ready=0, stay in ARB with no timeout.
- SEND: mess_to_core and frame_being_sent stay stable until core_reading=1 is sampled. On acknowledge:
  - frame_being_sent drops next cycle.
  - rr_ptr=(grant+1) mod CORE_NUM.
  - If idx==DATA_DEPTH-1, go to DONE; otherwise idx+1 and go to ARB.
- Changes to core_ready during SEND are ignored; the grant is committed.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. The next load can be accepted in the IDLE cycle that follows.
- prog_loading while state!=IDLE is ignored; the buffer is not overwritten.
- Latency: prog_loading sampled at edge 0 gives ARB in cycle 1, and the first frame_being_sent=1 in cycle 2 if a core is ready. Minimum spacing is 2 cycles per frame, since ARB and SEND alternate.
- rr_ptr persists across loads; only reset clears it.

Test Plan:
(Benches use defaults CORE_NUM=4, INSTR_SIZE=32, DATA_DEPTH=8, frame i = 32'hA000_000i.)
1. Assert reset=0 mid-cycle with stimulus active -> all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE and busy=0.
2. core_ready=4'b1111, core_reading tied 1, one-cycle prog_loading at edge 0 -> frame i is sent in cycle 2+2i to core i mod 4 (cores 0,1,2,3,0,1,2,3); mess_to_core for i=5 = {2'd1, 3'd5, 32'hA000_0005}; done=1 in cycle 17 only.
3. core_ready=4'b0100 throughout -> all 8 frames carry core_id=2; done pulses once.
4. core_ready=0 for 5 cycles after load, then 4'b0010 -> frame_being_sent stays 0 while stalled; first message carries core_id=1, idx=0.
5. core_reading held 0 for 3 SEND cycles, and core_ready dropped to 0 during that time -> mess_to_core is bit-stable for all 3 cycles; frame advances only after core_reading=1.
6. prog_loading pulsed again mid-load with different data -> ignored; the remaining frames still match the first capture. The second load is accepted only after done.
